// File: rtl/ex_logic_pipe_pkg.sv
// rtl/ex_logic_pipe_pkg.sv - shared op encodings and constants for the EX logic pipe
package ex_logic_pipe_pkg;
   localparam logic [7:0] EXE_AND_OP = 8'h24;
   localparam logic [7:0] EXE_OR_OP  = 8'h25;
   localparam logic [7:0] EXE_XOR_OP = 8'h26;
   localparam logic [7:0] EXE_NOR_OP = 8'h27;
   localparam logic [7:0] EXE_LUI_OP = 8'h5C;
   localparam logic [7:0] EXE_SLL_OP = 8'h7C;
   localparam logic [7:0] EXE_SRL_OP = 8'h02;
   localparam logic [7:0] EXE_SRA_OP = 8'h03;
   localparam logic [7:0] EXE_CLZ_OP = 8'hB0;
   localparam logic [7:0] EXE_CLO_OP = 8'hB1;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;
endpackage

// File: rtl/ex_logic_pipe_clz.sv
// rtl/ex_logic_pipe_clz.sv - combinational leading-zero counter
// An all-zero input counts as DATA_W.
module ex_logic_pipe_clz
   import ex_logic_pipe_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic [DATA_W-1:0] i_data,
   output logic [CNT_W-1:0]  o_count
);

   logic [CNT_W-1:0] w_count;
   logic             w_found;

   always_comb begin
      w_count = CNT_W'(DATA_W);
      w_found = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (!w_found && i_data[i]) begin
            w_count = CNT_W'(DATA_W - 1 - i);
            w_found = 1'b1;
         end
      end
   end

   assign o_count = w_count;

endmodule

// File: rtl/ex_logic_pipe.sv
// rtl/ex_logic_pipe.sv - two-stage pipelined logic/shift/count unit for the EX stage
// S1 holds the captured request, S2 holds the computed result; flush kills both.
module ex_logic_pipe
   import ex_logic_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 8,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [OP_W-1:0]   alu_op_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] result_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic              illegal_o
);

   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = SH_W + 1;
   localparam int HALF  = DATA_W / 2;

   logic              r_s1_valid;
   logic [OP_W-1:0]   r_s1_op;
   logic [DATA_W-1:0] r_s1_a;
   logic [DATA_W-1:0] r_s1_b;
   logic [TAG_W-1:0]  r_s1_tag;

   logic              r_s2_valid;
   logic [DATA_W-1:0] r_result;
   logic [TAG_W-1:0]  r_tag;
   logic              r_illegal;

   logic              w_s2_load;
   logic              w_s1_adv;
   logic              w_accept;
   logic [SH_W-1:0]   w_shamt;
   logic [DATA_W-1:0] w_clz_in;
   logic [CNT_W-1:0]  w_clz_count;
   logic [DATA_W-1:0] w_result;
   logic              w_illegal;

   assign w_s2_load  = !r_s2_valid || out_ready_i;
   assign w_s1_adv   = r_s1_valid && w_s2_load;
   assign in_ready_o = !flush_i && (!r_s1_valid || w_s1_adv);
   assign w_accept   = in_valid_i && in_ready_o;

   assign w_shamt  = r_s1_a[SH_W-1:0];
   // CLO reuses the zero counter on the inverted operand.
   assign w_clz_in = (r_s1_op == EXE_CLO_OP) ? ~r_s1_a : r_s1_a;

   ex_logic_pipe_clz #(.DATA_W(DATA_W)) u_clz (
      .i_data  (w_clz_in),
      .o_count (w_clz_count)
   );

   always_comb begin
      w_result  = '0;
      w_illegal = 1'b0;
      case (r_s1_op)
         EXE_AND_OP: w_result = r_s1_a & r_s1_b;
         EXE_OR_OP:  w_result = r_s1_a | r_s1_b;
         EXE_XOR_OP: w_result = r_s1_a ^ r_s1_b;
         EXE_NOR_OP: w_result = ~(r_s1_a | r_s1_b);
         EXE_LUI_OP: w_result = {r_s1_b[HALF-1:0], {HALF{1'b0}}};
         EXE_SLL_OP: w_result = r_s1_b << w_shamt;
         EXE_SRL_OP: w_result = r_s1_b >> w_shamt;
         EXE_SRA_OP: w_result = $signed(r_s1_b) >>> w_shamt;
         EXE_CLZ_OP,
         EXE_CLO_OP: w_result = DATA_W'(w_clz_count);
         default:    w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= '0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_tag   <= '0;
      end else begin
         if (flush_i) begin
            r_s1_valid <= 1'b0;
         end else if (!r_s1_valid || w_s1_adv) begin
            r_s1_valid <= w_accept;
         end
         if (w_accept) begin
            r_s1_op  <= alu_op_i;
            r_s1_a   <= reg1_i;
            r_s1_b   <= reg2_i;
            r_s1_tag <= tag_i;
         end
      end
   end

   // Result fields only change on a real S1 move, so they hold under backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_tag      <= '0;
         r_illegal  <= 1'b0;
      end else if (flush_i) begin
         r_s2_valid <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result  <= w_result;
            r_tag     <= r_s1_tag;
            r_illegal <= w_illegal;
         end
      end
   end

   assign out_valid_o = r_s2_valid;
   assign result_o    = r_result;
   assign tag_o       = r_tag;
   assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_ex_logic_pipe.sv
// tb/tb_ex_logic_pipe.sv - directed self-checking bench for ex_logic_pipe
module tb_ex_logic_pipe;
   import ex_logic_pipe_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [7:0]  alu_op_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic [4:0]  tag_i;
   logic        flush_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] result_o;
   logic [4:0]  tag_o;
   logic        illegal_o;

   int tests_run = 0;
   int tests_failed = 0;

   ex_logic_pipe #(.DATA_W(32), .OP_W(8), .TAG_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .alu_op_i    (alu_op_i),
      .reg1_i      (reg1_i),
      .reg2_i      (reg2_i),
      .tag_i       (tag_i),
      .flush_i     (flush_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .tag_o       (tag_o),
      .illegal_o   (illegal_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      in_valid_i = 1'b1;
      alu_op_i   = op;
      reg1_i     = a;
      reg2_i     = b;
      tag_i      = tag;
   endtask

   // Issues one request on an idle pipe and samples the outputs two cycles later.
   task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res, output logic [4:0] tg,
                        output logic ill, output logic vld);
      @(negedge clk);
      drive(op, a, b, tag);
      @(negedge clk);
      in_valid_i = 1'b0;
      @(negedge clk);
      res = result_o;
      tg  = tag_o;
      ill = illegal_o;
      vld = out_valid_o;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests_run++;
      if (out_valid_o !== 1'b0) begin
         tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid_o);
      end
      tests_run++;
      if (result_o !== 32'h0 || tag_o !== 5'h0 || illegal_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got res=%h tag=%h ill=%b want 0/0/0", result_o, tag_o, illegal_o);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (in_ready_o !== 1'b1) begin
         tests_failed++; $display("FAIL reset_ready: got %b want 1", in_ready_o);
      end
   endtask

   task automatic test_basic();
      @(negedge clk);
      drive(EXE_AND_OP, 32'hF0F0_00FF, 32'h0FF0_FF0F, 5'd3);
      @(negedge clk);
      drive(EXE_NOR_OP, 32'hF0F0_00FF, 32'h0FF0_FF0F, 5'd4);
      @(negedge clk);
      in_valid_i = 1'b0;
      tests_run++;
      if (out_valid_o !== 1'b1 || result_o !== 32'h00F0_000F || tag_o !== 5'd3 || illegal_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_and: got v=%b res=%h tag=%0d ill=%b want 1/00f0000f/3/0",
                  out_valid_o, result_o, tag_o, illegal_o);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid_o !== 1'b1 || result_o !== 32'h000F_0000 || tag_o !== 5'd4 || illegal_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_nor: got v=%b res=%h tag=%0d ill=%b want 1/000f0000/4/0",
                  out_valid_o, result_o, tag_o, illegal_o);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid_o !== 1'b0) begin
         tests_failed++; $display("FAIL basic_drain: got v=%b want 0", out_valid_o);
      end
   endtask

   task automatic test_shift_lui();
      logic [7:0]  ops [5] = '{EXE_SRA_OP, EXE_SRL_OP, EXE_SLL_OP, EXE_SLL_OP, EXE_LUI_OP};
      logic [31:0] r1s [5] = '{32'h4, 32'h4, 32'd31, 32'h25, 32'h0};
      logic [31:0] r2s [5] = '{32'h8000_0010, 32'h8000_0010, 32'h1, 32'h0000_0003, 32'h1234_ABCD};
      logic [31:0] exps[5] = '{32'hF800_0001, 32'h0800_0001, 32'h8000_0000, 32'h0000_0060, 32'hABCD_0000};
      logic [31:0] res;
      logic [4:0]  tg;
      logic        ill, vld;
      for (int i = 0; i < 5; i++) begin
         do_op(ops[i], r1s[i], r2s[i], 5'(i + 10), res, tg, ill, vld);
         tests_run++;
         if (vld !== 1'b1 || res !== exps[i] || tg !== 5'(i + 10) || ill !== 1'b0) begin
            tests_failed++;
            $display("FAIL shift_lui[%0d]: got v=%b res=%h tag=%0d ill=%b want 1/%h/%0d/0",
                     i, vld, res, tg, ill, exps[i], i + 10);
         end
      end
   endtask

   task automatic test_count();
      logic [7:0]  ops [4] = '{EXE_CLZ_OP, EXE_CLZ_OP, EXE_CLO_OP, EXE_CLO_OP};
      logic [31:0] r1s [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'hF000_0000};
      logic [31:0] exps[4] = '{32'd32, 32'd31, 32'd32, 32'd4};
      logic [31:0] res;
      logic [4:0]  tg;
      logic        ill, vld;
      for (int i = 0; i < 4; i++) begin
         do_op(ops[i], r1s[i], 32'h5A5A_5A5A, 5'd20, res, tg, ill, vld);
         tests_run++;
         if (vld !== 1'b1 || res !== exps[i] || ill !== 1'b0) begin
            tests_failed++;
            $display("FAIL count[%0d]: got v=%b res=%0d ill=%b want 1/%0d/0", i, vld, res, ill, exps[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  ops [4] = '{EXE_XOR_OP, EXE_OR_OP, EXE_AND_OP, EXE_SLL_OP};
      logic [31:0] r1s [4] = '{32'hFFFF_0000, 32'h0000_0011, 32'h0000_FFFF, 32'h0000_0008};
      logic [31:0] r2s [4] = '{32'h0000_FFFF, 32'h0000_0100, 32'h00FF_00FF, 32'h0000_00AB};
      logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'h0000_0111, 32'h0000_00FF, 32'h0000_AB00};
      int in_idx = 0;
      int out_idx = 0;
      int stall_left = 0;
      bit started = 1'b0;
      bit fin, fout, stalled;
      for (int cyc = 0; cyc < 14; cyc++) begin
         @(negedge clk);
         if (out_valid_o && !started) begin
            started = 1'b1;
            stall_left = 3;
         end
         stalled = (stall_left > 0);
         out_ready_i = !stalled;
         if (stall_left > 0) stall_left--;
         if (in_idx < 4) drive(ops[in_idx], r1s[in_idx], r2s[in_idx], 5'(in_idx + 1));
         else in_valid_i = 1'b0;
         #1;
         fin  = in_valid_i && in_ready_o;
         fout = out_valid_o && out_ready_i;
         if (stalled) begin
            tests_run++;
            if (in_ready_o !== 1'b0 || result_o !== exps[0] || tag_o !== 5'd1) begin
               tests_failed++;
               $display("FAIL b2b_stall cyc%0d: got rdy=%b res=%h tag=%0d want 0/%h/1",
                        cyc, in_ready_o, result_o, tag_o, exps[0]);
            end
         end
         if (fout) begin
            tests_run++;
            if (out_idx >= 4 || result_o !== exps[out_idx] || tag_o !== 5'(out_idx + 1)) begin
               tests_failed++;
               $display("FAIL b2b_order[%0d]: got res=%h tag=%0d", out_idx, result_o, tag_o);
            end
            out_idx++;
         end
         @(posedge clk);
         if (fin) in_idx++;
      end
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      tests_run++;
      if (in_idx != 4 || out_idx != 4 || !started) begin
         tests_failed++;
         $display("FAIL b2b_count: got in=%0d out=%0d started=%0b want 4/4/1", in_idx, out_idx, started);
      end
   endtask

   task automatic test_flush();
      logic [31:0] res;
      logic [4:0]  tg;
      logic        ill, vld;
      bit          seen;
      @(negedge clk);
      drive(EXE_OR_OP, 32'h1, 32'h2, 5'd5);
      @(negedge clk);
      drive(EXE_OR_OP, 32'h4, 32'h8, 5'd6);
      @(negedge clk);
      drive(EXE_OR_OP, 32'h10, 32'h20, 5'd7);
      flush_i = 1'b1;
      #1;
      tests_run++;
      if (in_ready_o !== 1'b0) begin
         tests_failed++; $display("FAIL flush_ready: got %b want 0", in_ready_o);
      end
      @(negedge clk);
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (out_valid_o !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      tests_run++;
      if (seen) begin
         tests_failed++; $display("FAIL flush_stale: got out_valid=1 after flush want 0");
      end
      do_op(EXE_XOR_OP, 32'h0000_00F0, 32'h0000_00FF, 5'd9, res, tg, ill, vld);
      tests_run++;
      if (vld !== 1'b1 || res !== 32'h0000_000F || tg !== 5'd9 || ill !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_next: got v=%b res=%h tag=%0d ill=%b want 1/0000000f/9/0", vld, res, tg, ill);
      end
   endtask

   task automatic test_illegal_reset();
      logic [31:0] res;
      logic [4:0]  tg;
      logic        ill, vld;
      do_op(8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, res, tg, ill, vld);
      tests_run++;
      if (vld !== 1'b1 || res !== 32'h0 || ill !== 1'b1 || tg !== 5'd11) begin
         tests_failed++;
         $display("FAIL illegal: got v=%b res=%h ill=%b tag=%0d want 1/0/1/11", vld, res, ill, tg);
      end
      @(negedge clk);
      out_ready_i = 1'b0;
      drive(EXE_OR_OP, 32'h5, 32'h0, 5'd7);
      @(negedge clk);
      in_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (out_valid_o !== 1'b1 || result_o !== 32'h5 || tag_o !== 5'd7) begin
         tests_failed++;
         $display("FAIL stall_hold: got v=%b res=%h tag=%0d want 1/5/7", out_valid_o, result_o, tag_o);
      end
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if (out_valid_o !== 1'b0 || result_o !== 32'h0 || tag_o !== 5'h0 || illegal_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: got v=%b res=%h tag=%h ill=%b want all 0",
                  out_valid_o, result_o, tag_o, illegal_o);
      end
      @(negedge clk);
      rst = 1'b1;
      out_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL post_reset: got v=%b rdy=%b want 0/1", out_valid_o, in_ready_o);
      end
   endtask

   initial begin
      rst         = 1'b0;
      in_valid_i  = 1'b0;
      alu_op_i    = 8'h0;
      reg1_i      = 32'h0;
      reg2_i      = 32'h0;
      tag_i       = 5'h0;
      flush_i     = 1'b0;
      out_ready_i = 1'b1;
      test_reset();
      test_basic();
      test_shift_lui();
      test_count();
      test_back_to_back();
      test_flush();
      test_illegal_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ex_logic_pipe.md
Name: ex_logic_pipe

Overview:
- Parametrised, pipelined logic/bit-manipulation unit for the EX stage.
- Supersedes the single-cycle combinational logic unit. Adds shift, LUI and count-leading-zeros/ones operations, a destination tag, a valid/ready handshake on both sides, and flush support.
- Sits between the ID/EX register and the EX result mux. Two-stage internal pipeline.

Parameters:
- DATA_W, 32, operand/result width; power of two, at least 16.
- OP_W, 8, width of alu_op_i; op encodings are the shared EXE_*_OP constants.
- TAG_W, 5, width of the destination-register tag carried alongside each op.

Ports:
- clk  in  1  clock; all flops rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  request present.
- in_ready_o  out  1  unit accepts a request this cycle.
- alu_op_i  in  OP_W  operation code.
- reg1_i  in  DATA_W  operand 1 (source of the shift amount for shift ops).
- reg2_i  in  DATA_W  operand 2 (shifted data; LUI source).
- tag_i  in  TAG_W  destination tag.
- flush_i  in  1  kill all in-flight ops (branch/exception).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer takes result.
- result_o  out  DATA_W  result.
- tag_o  out  TAG_W  tag of the result.
- illegal_o  out  1  op code not supported; qualified by out_valid_o.

Behaviour:
- Reset (rst=0, async): all stage valid bits, result_o, tag_o and illegal_o clear to 0. in_ready_o reads 1 once reset deasserts.
- Stage S1 captures op/operands/tag when in_valid_i & in_ready_o. Stage S2 holds the computed result.
- Latency: 2 cycles from acceptance to out_valid_o, with no backpressure. Throughput: 1 op per cycle.
- Advance rules:
  - S2 loads when S2 is empty or out_ready_i=1.
  - S1 loads when S1 is empty or S1 moves to S2.
  - in_ready_o = !flush_i & (!s1_valid | s1_advance).
- Backpressure: while out_valid_o=1 and out_ready_i=0, result_o/tag_o/illegal_o hold stable, and S1 stalls once full.
- flush_i=1: both valid bits clear on the next edge. Any input presented in that cycle is not accepted (in_ready_o=0). Outputs drop valid the cycle after the flush.
- Result computation in S1→S2 (combinational between the stages), with shamt = reg1[log2(DATA_W)-1:0]:
  - AND: r1&r2. OR: r1|r2. XOR: r1^r2. NOR: ~(r1|r2).
  - LUI: r2[DATA_W/2-1:0] placed in the upper half, lower half zero.
  - SLL: r2<<shamt. SRL: r2>>shamt, logical. SRA: r2>>>shamt, arithmetic (sign fill).
  - CLZ: count of leading zeros of r1; CLZ(0)=DATA_W. CLO: count of leading ones of r1; CLO(all ones)=DATA_W. Count is zero-extended.
  - Any other op: result 0, illegal_o=1. Every op listed above gives illegal_o=0.
- Simultaneous events:
  - flush_i has priority over accept and advance.
  - Output consumption and a new S1→S2 move in the same cycle are allowed (full throughput).
- Reset mid-operation: in-flight ops are discarded, with no output handshake.

Decomposition:
- Shared defines header holds:
  - EXE_AND/OR/XOR/NOR/LUI/SLL/SRL/SRA/CLZ/CLO_OP encodings (OP_W bits).
  - ZeroWord.
- One natural sub-module: ex_logic_pipe_clz. Combinational leading-zero counter, parametrised by DATA_W. CLO is computed by inverting the input.
- The S1/S2 handshake registers stay in the top module.

Test Plan:
- Reset and basic ops, DATA_W=32: AND r1=0xF0F0_00FF, r2=0x0FF0_FF0F, then NOR with the same operands, no backpressure → 0x00F0_000F after 2 cycles, then 0x000F_0000; tag echoed; illegal_o=0.
- Shifts and LUI: SRA r2=0x8000_0010 shamt=4 → 0xF800_0001. SRL with the same operands → 0x0800_0001. SLL r2=1 shamt=31 → 0x8000_0000. SLL where r1=0x0000_0025 (only the low 5 bits are used, so shamt=5) → r2<<5. LUI r2=0x1234_ABCD → 0xABCD_0000.
- CLZ/CLO corners: CLZ(0)=32, CLZ(0x0000_0001)=31, CLO(0xFFFF_FFFF)=32, CLO(0xF000_0000)=4.
- Back-to-back with backpressure: 4 ops issued on consecutive cycles, out_ready_i=0 for 3 cycles from the first out_valid_o. Required:
  - in_ready_o drops after 2 ops are buffered.
  - result_o stays stable while stalled.
  - all 4 results exit in order, none lost or duplicated.
- Flush: 2 ops in flight, flush_i=1 for one cycle with in_valid_i=1. Required:
  - in_ready_o=0 that cycle.
  - out_valid_o=0 afterwards; no stale result appears.
  - the next request completes normally in 2 cycles.
- Illegal op and async reset: op=0xFF → result 0, illegal_o=1. Then assert rst low asynchronously mid-stall → out_valid_o falls immediately and all outputs read 0.
